// File: rtl/dma_stream_demux1to2_if.sv
// Stream bundle for the 1-to-2 demultiplexer: one source stream with a
// destination select, and two registered destination streams.
interface dma_stream_demux1to2_if #(
  parameter int SIZE = 8
);

  logic [SIZE-1:0] in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_sel;
  logic            in_ready;

  logic [SIZE-1:0] out0_data;
  logic            out0_valid;
  logic            out0_last;
  logic            out0_ready;

  logic [SIZE-1:0] out1_data;
  logic            out1_valid;
  logic            out1_last;
  logic            out1_ready;

  // Producer of the source stream and consumer of both destinations.
  modport master (
    output in_data, in_valid, in_last, in_sel,
    input  in_ready,
    input  out0_data, out0_valid, out0_last,
    output out0_ready,
    input  out1_data, out1_valid, out1_last,
    output out1_ready
  );

  // The demultiplexer itself.
  modport slave (
    input  in_data, in_valid, in_last, in_sel,
    output in_ready,
    output out0_data, out0_valid, out0_last,
    input  out0_ready,
    output out1_data, out1_valid, out1_last,
    input  out1_ready
  );

endinterface

// File: rtl/dma_stream_demux1to2.sv
// Registered 1-to-2 packet stream demultiplexer. The destination is taken
// from in_sel on the first beat of a packet and held until the last beat.
// Each destination has its own single-entry output register, so a stalled
// destination only blocks packets routed to it.
module dma_stream_demux1to2 #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  dma_stream_demux1to2_if.slave s,
  output logic             busy,
  output logic             route,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ROUTE = 1'b1;

  logic [0:0]      state;

  logic [SIZE-1:0] out0_data_p0;
  logic            out0_last_p0;
  logic            vld_p0_0;
  logic [SIZE-1:0] out1_data_p0;
  logic            out1_last_p0;
  logic            vld_p0_1;

  logic            dest;
  logic            dest_free;
  logic            in_fire;
  logic            load0;
  logic            load1;
  logic            fire0;
  logic            fire1;

  // Destination for the current beat: live select on a packet's first beat,
  // latched route for the rest. The target register may accept when it is
  // empty or being drained in this same cycle.
  always_comb begin
    dest      = (state == IDLE) ? s.in_sel : route;
    dest_free = dest ? (~vld_p0_1 | s.out1_ready) : (~vld_p0_0 | s.out0_ready);
  end

  assign s.in_ready = ~rst & dest_free;
  assign in_fire    = s.in_valid & s.in_ready;
  assign load0      = in_fire & ~dest;
  assign load1      = in_fire & dest;
  assign fire0      = vld_p0_0 & s.out0_ready;
  assign fire1      = vld_p0_1 & s.out1_ready;

  // Packet framing: latch route on the first beat, return to IDLE on last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      route <= 1'b0;
    end else if (in_fire) begin
      if (state == IDLE) begin
        route <= s.in_sel;
      end
      state <= s.in_last ? IDLE : ROUTE;
    end
  end

  // ---- stage p0: destination 0 output register ----
  // Refill takes priority over drain so a drain+refill edge keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_data_p0 <= '0;
      out0_last_p0 <= 1'b0;
      vld_p0_0     <= 1'b0;
    end else if (load0) begin
      out0_data_p0 <= s.in_data;
      out0_last_p0 <= s.in_last;
      vld_p0_0     <= 1'b1;
    end else if (fire0) begin
      vld_p0_0     <= 1'b0;
    end
  end

  // ---- stage p0: destination 1 output register ----
  // Same refill-over-drain priority as destination 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1_data_p0 <= '0;
      out1_last_p0 <= 1'b0;
      vld_p0_1     <= 1'b0;
    end else if (load1) begin
      out1_data_p0 <= s.in_data;
      out1_last_p0 <= s.in_last;
      vld_p0_1     <= 1'b1;
    end else if (fire1) begin
      vld_p0_1     <= 1'b0;
    end
  end

  // Completed-packet counters, bumped when a last beat leaves its output.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (fire0 && out0_last_p0) begin
        pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      end
      if (fire1 && out1_last_p0) begin
        pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
      end
    end
  end

  assign busy         = (state == ROUTE);
  assign s.out0_data  = out0_data_p0;
  assign s.out0_last  = out0_last_p0;
  assign s.out0_valid = vld_p0_0;
  assign s.out1_data  = out1_data_p0;
  assign s.out1_last  = out1_last_p0;
  assign s.out1_valid = vld_p0_1;

endmodule

// File: doc/dma_stream_demux1to2.md
Name: dma_stream_demux1to2

Overview:
- Registered 1-to-2 stream demultiplexer for the DMA core.
- Steers one packetised source stream (valid/ready/last) to one of two destination streams.
- Destination is chosen by a select sampled on the first beat of each packet and held until the last beat.
- Counterpart to the 2-to-1 data selection used on the DMA merge path; adds per-output pipeline registers and packet-level routing.

Parameters:
SIZE, 8, data width in bits of input and both outputs
CNT_W, 16, width of the per-output packet counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_data  input  SIZE  source beat data
in_valid  input  1  source beat valid
in_last  input  1  final beat of packet
in_sel  input  1  destination select (0=out0, 1=out1), sampled on first beat only
in_ready  output  1  block can accept a beat this cycle
out0_data  output  SIZE  destination 0 data (registered)
out0_valid  output  1  destination 0 beat valid
out0_last  output  1  destination 0 last flag
out0_ready  input  1  destination 0 accepts beat
out1_data  output  SIZE  destination 1 data (registered)
out1_valid  output  1  destination 1 beat valid
out1_last  output  1  destination 1 last flag
out1_ready  input  1  destination 1 accepts beat
busy  output  1  high while a packet is mid-route (state ROUTE)
route  output  1  currently latched destination
pkt_cnt0  output  CNT_W  completed packets delivered to out0
pkt_cnt1  output  CNT_W  completed packets delivered to out1

Behaviour:
- Reset, synchronous, in clk edge with rst=1: state=IDLE, route=0, busy=0, outN_valid=0, outN_last=0, outN_data=0, pkt_cnt0=pkt_cnt1=0.
- Reset mid-packet: all buffered beats are discarded; in_ready is 0 during the rst cycle.
- Transfer occurs when valid & ready are both high at a clk edge; this applies to input and to each output.
- FSM has two states, IDLE and ROUTE.
  - IDLE: effective destination d = in_sel. On an input transfer, route<=in_sel. If in_last=0, go to ROUTE; otherwise stay in IDLE (single-beat packet).
  - ROUTE: d = route. in_sel is ignored. An input transfer with in_last=1 returns the FSM to IDLE.
- in_ready = ~outd_valid | outd_ready. It is combinational from the output register state and the destination ready; it never depends on in_valid.
- The non-selected output never blocks the input. It keeps draining independently.
- Output register N on input transfer to N: outN_data<=in_data, outN_last<=in_last, outN_valid<=1.
- Output register N otherwise: if outN_valid & outN_ready, outN_valid<=0.
- Simultaneous drain and refill of the same register in one cycle is required (full throughput, one beat per clk).
- Latency: input transfer at edge k makes the beat visible on outN at edge k (valid after edge k); one register stage.
- Outputs hold data/last stable while outN_valid=1 and outN_ready=0.
- pkt_cntN increments by 1 on each outN transfer with outN_last=1. It wraps modulo 2^CNT_W. Both counters may increment in the same cycle.
- busy = (state==ROUTE).
- Packets to different outputs may be in flight simultaneously: a new packet may target out1 while out0 still holds an undrained last beat.

Test Plan:
- Reset then single-beat packet: in_sel=1, in_data=8'hA5, in_last=1, out1_ready=1 → out1_valid high one cycle later with 8'hA5, last=1; pkt_cnt1=1; out0_valid stays 0; busy stays 0.
- 4-beat packet, in_sel=0 on beat 0, in_sel toggled on beats 1–3, data 1..4, both ready=1 → all 4 beats on out0 in order, one per cycle; busy high from after beat 0 until after beat 3; pkt_cnt0=1.
- Backpressure: out0_ready=0 with out0 holding beat 8'h11 → in_ready=0 for route 0; out0_data holds 8'h11; releasing out0_ready gives same-cycle drain+refill with no bubble.
- Cross-output overlap: out0 stalled holding a last beat, next packet in_sel=1 → in_ready=1, packet flows to out1; pkt_cnt0 increments only once out0_ready rises.
- Reset mid-packet after beat 2 of 5 → all valids 0 next cycle, busy=0, counters 0; the next beat is treated as a new packet using its in_sel.
- Wrap: CNT_W=2, 5 single-beat packets to out0 → pkt_cnt0 sequence 1,2,3,0,1.
